// File: rtl/snake_ctl_pkg.sv
// -----------------------------------------------------------------------------
// snake_ctl_pkg
// Shared definitions for the snake game-state controller:
//   - coordinate widths (7-bit column, 6-bit row) and the packed body cell
//   - direction codes (0 right, 1 down, 2 left, 3 up)
//   - controller FSM state codes
//   - the three-cell body the game starts from after reset
//   - a helper returning the direction opposite to a given one
// -----------------------------------------------------------------------------
package snake_ctl_pkg;

    localparam int X_W    = 7;
    localparam int Y_W    = 6;
    localparam int CELL_W = X_W + Y_W;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        APPLE_WAIT = 3'd1,
        IDLE       = 3'd2,
        MOVE       = 3'd3,
        SCAN       = 3'd4,
        COMMIT     = 3'd5,
        OVER       = 3'd6
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } cell_t;

    // Starting body lies on row 12, tail at column 14 and head at column 16.
    localparam logic [X_W-1:0] RESET_TAIL_X = 7'd14;
    localparam logic [X_W-1:0] RESET_MID_X  = 7'd15;
    localparam logic [X_W-1:0] RESET_HEAD_X = 7'd16;
    localparam logic [Y_W-1:0] RESET_Y      = 6'd12;
    localparam int             RESET_LEN    = 3;

    // Right/left and down/up differ only in the upper code bit, so flipping
    // that bit yields the reverse heading.
    function automatic dir_t opposite_dir(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_body_ram.sv
// -----------------------------------------------------------------------------
// snake_body_ram
// Ring buffer holding the snake body, one cell (column,row) per entry.
// Body entry k (0 = head) lives at mem[(head_ptr - k) mod MAX_LEN], so the
// buffer never has to shift: a step just advances head_ptr and writes the new
// head in front of the old one. The oldest slot is simply left behind when
// the snake does not grow.
//
// Ports:
//   pclk, rst   clock and synchronous active-high reset
//   wr_en       advance head_ptr and store wr_cell as the new head
//   wr_cell     new head cell
//   scan_idx    body index for the collision scan, scan_cell 1 cycle later
//   rd_idx      body index for the drawing stage, rd_cell 1 cycle later
// -----------------------------------------------------------------------------
module snake_body_ram
    import snake_ctl_pkg::*;
#(
    parameter  int MAX_LEN = 64,
    localparam int IW      = $clog2(MAX_LEN)
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          wr_en,
    input  cell_t         wr_cell,
    input  logic [IW-1:0] scan_idx,
    output cell_t         scan_cell,
    input  logic [IW-1:0] rd_idx,
    output cell_t         rd_cell
);

    cell_t         mem [MAX_LEN];
    logic [IW-1:0] head_ptr;
    logic [IW-1:0] wr_ptr;

    assign wr_ptr = head_ptr + 1'b1;

    // Storage and head pointer. Reset rebuilds the starting body so that a
    // reset in the middle of a game returns to the same picture; slots 0..2
    // hold tail..head and head_ptr points at slot 2.
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                mem[i] <= '0;
            end
            mem[0]   <= '{x: RESET_TAIL_X, y: RESET_Y};
            mem[1]   <= '{x: RESET_MID_X,  y: RESET_Y};
            mem[2]   <= '{x: RESET_HEAD_X, y: RESET_Y};
            head_ptr <= IW'(2);
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_cell;
            head_ptr    <= wr_ptr;
        end
    end

    // Two independent synchronous read ports. The subtraction wraps modulo
    // MAX_LEN naturally because the pointer is exactly IW bits wide. The
    // drawing port never waits on the collision scan.
    always_ff @(posedge pclk) begin
        if (rst) begin
            scan_cell <= '0;
            rd_cell   <= '0;
        end else begin
            scan_cell <= mem[head_ptr - scan_idx];
            rd_cell   <= mem[head_ptr - rd_idx];
        end
    end

endmodule

// File: rtl/snake_ctl.sv
// -----------------------------------------------------------------------------
// snake_ctl
// Game-state controller for the snake display pipeline. Every FRAMES_PER_STEP
// vsync rising edges the snake moves one cell in its latched direction. The
// new head is checked against the walls, then against the body one entry per
// cycle; eating the apple grows the snake and asks the coordinate generator
// for a new apple over a req/ack handshake.
//
// Ports:
//   pclk, rst               pixel clock, synchronous active-high reset
//   vsync_in                vsync from the timing chain (edge detected here)
//   dir_in, dir_valid       requested direction and its one-cycle qualifier
//   apple_req               asking for a new apple position
//   apple_ack, apple_x_in,
//   apple_y_in              candidate apple position from the generator
//   apple_x, apple_y        current apple position
//   head_x, head_y          current head position
//   snake_len               current length, 3..MAX_LEN
//   step_done               one-cycle pulse when a step commits
//   game_over               sticky collision flag
//   rd_idx                  body index for drawing (0 = head)
//   rd_x, rd_y, rd_valid    cell at rd_idx one cycle later, and rd_idx < len
// -----------------------------------------------------------------------------
module snake_ctl
    import snake_ctl_pkg::*;
#(
    parameter  int GRID_W          = 32,
    parameter  int GRID_H          = 24,
    parameter  int MAX_LEN         = 64,
    parameter  int FRAMES_PER_STEP = 8,
    localparam int IW              = $clog2(MAX_LEN),
    localparam int LEN_W           = IW + 1,
    localparam int FC_W            = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             vsync_in,
    input  logic [1:0]       dir_in,
    input  logic             dir_valid,
    input  logic             apple_ack,
    input  logic [X_W-1:0]   apple_x_in,
    input  logic [Y_W-1:0]   apple_y_in,
    output logic             apple_req,
    output logic [X_W-1:0]   apple_x,
    output logic [Y_W-1:0]   apple_y,
    output logic [X_W-1:0]   head_x,
    output logic [Y_W-1:0]   head_y,
    output logic [LEN_W-1:0] snake_len,
    output logic             step_done,
    output logic             game_over,
    input  logic [IW-1:0]    rd_idx,
    output logic [X_W-1:0]   rd_x,
    output logic [Y_W-1:0]   rd_y,
    output logic             rd_valid
);

    state_t           state;
    state_t           next_state;

    logic             vsync_q;
    logic             vsync_rise;
    logic [FC_W-1:0]  frame_cnt;
    logic             frame_wrap;
    logic             step_tick;

    dir_t             pending;
    dir_t             dir_req;

    logic [X_W-1:0]   cand_x;
    logic [Y_W-1:0]   cand_y;
    logic             cand_wall;
    logic             cand_eat;
    logic             cand_grow;

    logic [X_W-1:0]   next_x;
    logic [Y_W-1:0]   next_y;
    logic             grow_q;
    logic             eat_q;

    logic [LEN_W-1:0] scan_cnt;
    logic [LEN_W-1:0] scan_cnt_inc;
    logic [LEN_W-1:0] scan_last;
    logic [IW-1:0]    scan_addr;
    logic             scan_hit;

    logic             wr_en;
    cell_t            scan_cell;
    cell_t            rd_cell;

    assign vsync_rise = vsync_in & ~vsync_q;
    assign frame_wrap = (frame_cnt == FC_W'(FRAMES_PER_STEP - 1));
    assign step_tick  = vsync_rise & frame_wrap & (state != OVER);
    assign dir_req    = dir_t'(dir_in);

    // Candidate head for the step being started, taken from the pending
    // direction (which is the heading adopted in MOVE). The wall test looks
    // at the current head so underflow from 0 never has to be decoded from a
    // wrapped value.
    always_comb begin
        cand_x    = head_x;
        cand_y    = head_y;
        cand_wall = 1'b0;
        case (pending)
            DIR_RIGHT: begin
                cand_x    = head_x + 1'b1;
                cand_wall = (head_x == X_W'(GRID_W - 1));
            end
            DIR_DOWN: begin
                cand_y    = head_y + 1'b1;
                cand_wall = (head_y == Y_W'(GRID_H - 1));
            end
            DIR_LEFT: begin
                cand_x    = head_x - 1'b1;
                cand_wall = (head_x == '0);
            end
            DIR_UP: begin
                cand_y    = head_y - 1'b1;
                cand_wall = (head_y == '0);
            end
            default: begin
                cand_wall = 1'b0;
            end
        endcase
    end

    assign cand_eat  = (cand_x == apple_x) && (cand_y == apple_y);
    assign cand_grow = cand_eat && (snake_len < LEN_W'(MAX_LEN));

    // The scan reads one body entry per cycle through a registered port, so
    // the address runs one entry ahead of the comparison: MOVE fetches entry
    // 0, and each SCAN cycle fetches the entry compared in the next cycle.
    // A growing snake keeps its tail, so the whole body is scanned; otherwise
    // the tail cell is about to be vacated and is skipped.
    assign scan_cnt_inc = scan_cnt + 1'b1;
    assign scan_addr    = (state == MOVE) ? '0 : scan_cnt_inc[IW-1:0];
    assign scan_last    = grow_q ? (snake_len - LEN_W'(1)) : (snake_len - LEN_W'(2));
    assign scan_hit     = (scan_cell.x == next_x) && (scan_cell.y == next_y);

    // State register.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and state-decoded outputs. Ticks arriving anywhere but IDLE
    // are dropped, and an ack outside APPLE_WAIT has no effect because only
    // that state looks at it. OVER is only left through reset.
    always_comb begin
        next_state = state;
        apple_req  = 1'b0;
        game_over  = 1'b0;
        wr_en      = 1'b0;
        case (state)
            INIT: begin
                next_state = APPLE_WAIT;
            end
            APPLE_WAIT: begin
                apple_req = 1'b1;
                if (apple_ack) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (step_tick) begin
                    next_state = MOVE;
                end
            end
            MOVE: begin
                next_state = cand_wall ? OVER : SCAN;
            end
            SCAN: begin
                if (scan_hit) begin
                    next_state = OVER;
                end else if (scan_cnt == scan_last) begin
                    next_state = COMMIT;
                end
            end
            COMMIT: begin
                wr_en      = 1'b1;
                next_state = eat_q ? APPLE_WAIT : IDLE;
            end
            OVER: begin
                game_over = 1'b1;
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    // Frame counter and direction latch. Both freeze once the game is over.
    // A requested direction is taken unless it reverses the direction the
    // snake will move in next, so a "down then up" pair between two steps
    // keeps down. A request during MOVE lands after the heading for the
    // current step was already taken, so it applies to the following step.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_q   <= 1'b0;
            frame_cnt <= '0;
            pending   <= DIR_RIGHT;
        end else begin
            vsync_q <= vsync_in;
            if (state != OVER) begin
                if (vsync_rise) begin
                    frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
                end
                if (dir_valid && (dir_req != opposite_dir(pending))) begin
                    pending <= dir_req;
                end
            end
        end
    end

    // Step datapath: MOVE freezes the candidate head and the grow/eat
    // decisions, SCAN advances the scan counter, COMMIT publishes the new
    // head and length together with the step_done pulse. The apple is
    // captured on the ack edge.
    always_ff @(posedge pclk) begin
        if (rst) begin
            apple_x   <= '0;
            apple_y   <= '0;
            head_x    <= RESET_HEAD_X;
            head_y    <= RESET_Y;
            snake_len <= LEN_W'(RESET_LEN);
            next_x    <= '0;
            next_y    <= '0;
            grow_q    <= 1'b0;
            eat_q     <= 1'b0;
            scan_cnt  <= '0;
            step_done <= 1'b0;
        end else begin
            step_done <= 1'b0;
            if ((state == APPLE_WAIT) && apple_ack) begin
                apple_x <= apple_x_in;
                apple_y <= apple_y_in;
            end
            if (state == MOVE) begin
                next_x   <= cand_x;
                next_y   <= cand_y;
                grow_q   <= cand_grow;
                eat_q    <= cand_eat;
                scan_cnt <= '0;
            end
            if (state == SCAN) begin
                scan_cnt <= scan_cnt_inc;
            end
            if (state == COMMIT) begin
                head_x    <= next_x;
                head_y    <= next_y;
                step_done <= 1'b1;
                if (grow_q) begin
                    snake_len <= snake_len + 1'b1;
                end
            end
        end
    end

    // Drawing-port qualifier, registered so it lines up with rd_x/rd_y and
    // reflects the length at the moment rd_idx was sampled.
    always_ff @(posedge pclk) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= ({1'b0, rd_idx} < snake_len);
        end
    end

    snake_body_ram #(
        .MAX_LEN (MAX_LEN)
    ) u_body (
        .pclk      (pclk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_cell   ('{x: next_x, y: next_y}),
        .scan_idx  (scan_addr),
        .scan_cell (scan_cell),
        .rd_idx    (rd_idx),
        .rd_cell   (rd_cell)
    );

    assign rd_x = rd_cell.x;
    assign rd_y = rd_cell.y;

endmodule

// File: tb/tb_snake_ctl.sv
// -----------------------------------------------------------------------------
// tb_snake_ctl
// Self-checking bench for snake_ctl. A reference model keeps the body as a
// queue of cells (head first) and applies the game rules directly: move the
// head, test walls and the body cells that stay occupied, grow on the apple.
// Directed scenarios are followed by randomized games.
// -----------------------------------------------------------------------------
module tb_snake_ctl;

    localparam int GRID_W  = 32;
    localparam int GRID_H  = 24;
    localparam int MAX_LEN = 64;
    localparam int FPS     = 8;

    logic       pclk       = 1'b0;
    logic       rst        = 1'b1;
    logic       vsync_in   = 1'b0;
    logic [1:0] dir_in     = 2'd0;
    logic       dir_valid  = 1'b0;
    logic       apple_ack  = 1'b0;
    logic [6:0] apple_x_in = '0;
    logic [5:0] apple_y_in = '0;
    logic [5:0] rd_idx     = '0;
    logic       apple_req;
    logic [6:0] apple_x;
    logic [5:0] apple_y;
    logic [6:0] head_x;
    logic [5:0] head_y;
    logic [6:0] snake_len;
    logic       step_done;
    logic       game_over;
    logic [6:0] rd_x;
    logic [5:0] rd_y;
    logic       rd_valid;

    int checks = 0;
    int errors = 0;

    logic [12:0] body_q[$];
    int          m_pending;
    int          m_apple_x;
    int          m_apple_y;
    bit          m_over;

    snake_ctl #(
        .GRID_W          (GRID_W),
        .GRID_H          (GRID_H),
        .MAX_LEN         (MAX_LEN),
        .FRAMES_PER_STEP (FPS)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .vsync_in   (vsync_in),
        .dir_in     (dir_in),
        .dir_valid  (dir_valid),
        .apple_ack  (apple_ack),
        .apple_x_in (apple_x_in),
        .apple_y_in (apple_y_in),
        .apple_req  (apple_req),
        .apple_x    (apple_x),
        .apple_y    (apple_y),
        .head_x     (head_x),
        .head_y     (head_y),
        .snake_len  (snake_len),
        .step_done  (step_done),
        .game_over  (game_over),
        .rd_idx     (rd_idx),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_valid   (rd_valid)
    );

    always #5 pclk = ~pclk;

    function automatic int dx_of(input int d);
        return (d == 0) ? 1 : ((d == 2) ? -1 : 0);
    endfunction

    function automatic int dy_of(input int d);
        return (d == 1) ? 1 : ((d == 3) ? -1 : 0);
    endfunction

    function automatic int qx(input int k);
        return int'(body_q[k][12:6]);
    endfunction

    function automatic int qy(input int k);
        return int'(body_q[k][5:0]);
    endfunction

    task automatic model_init();
        body_q.delete();
        body_q.push_back({7'd16, 6'd12});
        body_q.push_back({7'd15, 6'd12});
        body_q.push_back({7'd14, 6'd12});
        m_pending = 0;
        m_apple_x = 0;
        m_apple_y = 0;
        m_over    = 1'b0;
    endtask

    task automatic model_reset();
        rst       = 1'b1;
        vsync_in  = 1'b0;
        dir_valid = 1'b0;
        apple_ack = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b0;
        model_init();
    endtask

    task automatic vsync_pulse();
        vsync_in = 1'b1;
        @(posedge pclk);
        #1;
        vsync_in = 1'b0;
        @(posedge pclk);
        #1;
    endtask

    task automatic model_dir(input int d);
        dir_in    = 2'(d);
        dir_valid = 1'b1;
        @(posedge pclk);
        #1;
        dir_valid = 1'b0;
        if (d != (m_pending + 2) % 4) m_pending = d;
    endtask

    task automatic do_ack(input int x, input int y);
        int w;
        w = 0;
        while (apple_req !== 1'b1 && w < 8) begin
            @(posedge pclk);
            #1;
            w++;
        end
        checks++;
        if (apple_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL apple_req_high got %b expected 1", apple_req);
        end
        apple_x_in = 7'(x);
        apple_y_in = 6'(y);
        apple_ack  = 1'b1;
        @(posedge pclk);
        #1;
        apple_ack = 1'b0;
        checks++;
        if (apple_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL apple_req_drop got %b expected 0", apple_req);
        end
        checks++;
        if (apple_x !== 7'(x) || apple_y !== 6'(y)) begin
            errors++;
            $display("[TB] FAIL apple_capture got (%0d,%0d) expected (%0d,%0d)",
                     apple_x, apple_y, x, y);
        end
        m_apple_x = x;
        m_apple_y = y;
    endtask

    task automatic game_start(input int x, input int y);
        model_reset();
        do_ack(x, y);
    endtask

    // One full step: seven plain frames, then the wrapping frame, after which
    // the outcome predicted by the model is compared with the DUT.
    task automatic do_step(input bit mv_dir, input int mv_d);
        int          nx, ny, n, cyc;
        bit          wall, eat, grow, hit;
        logic [12:0] nc;
        for (int i = 0; i < FPS - 1; i++) vsync_pulse();
        nx   = qx(0) + dx_of(m_pending);
        ny   = qy(0) + dy_of(m_pending);
        wall = (nx < 0) || (nx >= GRID_W) || (ny < 0) || (ny >= GRID_H);
        nc   = {nx[6:0], ny[5:0]};
        eat  = !wall && (nx == m_apple_x) && (ny == m_apple_y);
        grow = eat && (body_q.size() < MAX_LEN);
        n    = grow ? body_q.size() : body_q.size() - 1;
        hit  = 1'b0;
        if (!wall) begin
            for (int k = 0; k < n; k++) if (body_q[k] == nc) hit = 1'b1;
        end
        vsync_in = 1'b1;
        cyc = 0;
        while (cyc < 300) begin
            @(posedge pclk);
            #1;
            cyc++;
            if (cyc == 1) begin
                vsync_in = 1'b0;
                if (mv_dir) begin
                    dir_in    = 2'(mv_d);
                    dir_valid = 1'b1;
                end
            end
            if (cyc == 2) dir_valid = 1'b0;
            if (step_done === 1'b1 || game_over === 1'b1) break;
        end
        if (wall || hit) begin
            checks++;
            if (game_over !== 1'b1) begin
                errors++;
                $display("[TB] FAIL collision_game_over got %b expected 1 (wall %0d hit %0d)",
                         game_over, wall, hit);
            end
            checks++;
            if (step_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL collision_no_step got %b expected 0", step_done);
            end
            checks++;
            if (head_x !== 7'(qx(0)) || head_y !== 6'(qy(0))) begin
                errors++;
                $display("[TB] FAIL collision_head got (%0d,%0d) expected (%0d,%0d)",
                         head_x, head_y, qx(0), qy(0));
            end
            m_over = 1'b1;
        end else begin
            body_q.push_front(nc);
            if (!grow) void'(body_q.pop_back());
            checks++;
            if (cyc != n + 3) begin
                errors++;
                $display("[TB] FAIL step_latency got %0d expected %0d", cyc, n + 3);
            end
            checks++;
            if (step_done !== 1'b1 || game_over !== 1'b0) begin
                errors++;
                $display("[TB] FAIL step_done got %b/%b expected 1/0", step_done, game_over);
            end
            checks++;
            if (head_x !== 7'(nx) || head_y !== 6'(ny)) begin
                errors++;
                $display("[TB] FAIL step_head got (%0d,%0d) expected (%0d,%0d)",
                         head_x, head_y, nx, ny);
            end
            checks++;
            if (snake_len !== 7'(body_q.size())) begin
                errors++;
                $display("[TB] FAIL step_len got %0d expected %0d", snake_len, body_q.size());
            end
            @(posedge pclk);
            #1;
            checks++;
            if (step_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL step_pulse got %b expected 0", step_done);
            end
            checks++;
            if (apple_req !== eat) begin
                errors++;
                $display("[TB] FAIL eat_req got %b expected %b", apple_req, eat);
            end
        end
        if (mv_dir && (mv_d != (m_pending + 2) % 4)) m_pending = mv_d;
    endtask

    task automatic check_rd(input int idx);
        bit exp_valid;
        rd_idx = 6'(idx);
        @(posedge pclk);
        #1;
        exp_valid = (idx < body_q.size());
        checks++;
        if (rd_valid !== exp_valid) begin
            errors++;
            $display("[TB] FAIL rd_valid idx %0d got %b expected %b", idx, rd_valid, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if (rd_x !== 7'(qx(idx)) || rd_y !== 6'(qy(idx))) begin
                errors++;
                $display("[TB] FAIL rd_cell idx %0d got (%0d,%0d) expected (%0d,%0d)",
                         idx, rd_x, rd_y, qx(idx), qy(idx));
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (head_x !== 7'd16 || head_y !== 6'd12 || snake_len !== 7'd3) begin
            errors++;
            $display("[TB] FAIL %s_head got (%0d,%0d) len %0d expected (16,12) len 3",
                     tag, head_x, head_y, snake_len);
        end
        checks++;
        if (apple_x !== 7'd0 || apple_y !== 6'd0) begin
            errors++;
            $display("[TB] FAIL %s_apple got (%0d,%0d) expected (0,0)", tag, apple_x, apple_y);
        end
        checks++;
        if ({apple_req, step_done, game_over, rd_valid} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL %s_flags got req %b done %b over %b valid %b expected all 0",
                     tag, apple_req, step_done, game_over, rd_valid);
        end
        checks++;
        if (rd_x !== 7'd0 || rd_y !== 6'd0) begin
            errors++;
            $display("[TB] FAIL %s_rd got (%0d,%0d) expected (0,0)", tag, rd_x, rd_y);
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        model_reset();
        check_reset_values("reset");
        @(posedge pclk);
        #1;
        checks++;
        if (apple_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL init_to_wait got %b expected 1", apple_req);
        end
        do_ack(5, 5);
        do_step(1'b0, 0);
        checks++;
        if (head_x !== 7'd17 || head_y !== 6'd12) begin
            errors++;
            $display("[TB] FAIL first_step got (%0d,%0d) expected (17,12)", head_x, head_y);
        end
    endtask

    task automatic test_wall();
        int guard;
        logic [6:0] ax;
        $display("[TB] test_wall");
        game_start(5, 5);
        guard = 0;
        while (!m_over && guard < 20) begin
            do_step(1'b0, 0);
            guard++;
        end
        checks++;
        if (head_x !== 7'd31 || game_over !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wall_stop got x %0d over %b expected 31 1", head_x, game_over);
        end
        model_dir(1);
        apple_x_in = 7'd1;
        apple_y_in = 6'd1;
        apple_ack  = 1'b1;
        for (int i = 0; i < 2 * FPS; i++) vsync_pulse();
        apple_ack = 1'b0;
        ax = apple_x;
        checks++;
        if (head_x !== 7'd31 || head_y !== 6'd12 || snake_len !== 7'd3 || ax !== 7'd5) begin
            errors++;
            $display("[TB] FAIL over_frozen got (%0d,%0d) len %0d apple_x %0d expected (31,12) 3 5",
                     head_x, head_y, snake_len, ax);
        end
        checks++;
        if (game_over !== 1'b1 || apple_req !== 1'b0 || step_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL over_flags got over %b req %b done %b expected 1 0 0",
                     game_over, apple_req, step_done);
        end
    endtask

    task automatic test_grow();
        $display("[TB] test_grow");
        game_start(17, 12);
        do_step(1'b0, 0);
        checks++;
        if (snake_len !== 7'd4 || apple_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL grow got len %0d req %b expected 4 1", snake_len, apple_req);
        end
        check_rd(3);
        checks++;
        if (rd_x !== 7'd14 || rd_y !== 6'd12) begin
            errors++;
            $display("[TB] FAIL grow_tail got (%0d,%0d) expected (14,12)", rd_x, rd_y);
        end
        check_rd(4);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL grow_past_tail got %b expected 0", rd_valid);
        end
        do_ack(3, 20);
    endtask

    task automatic test_dir();
        $display("[TB] test_dir");
        game_start(5, 5);
        model_dir(2);
        do_step(1'b0, 0);
        checks++;
        if (head_x !== 7'd17 || head_y !== 6'd12) begin
            errors++;
            $display("[TB] FAIL reverse_ignored got (%0d,%0d) expected (17,12)", head_x, head_y);
        end
        model_dir(1);
        model_dir(3);
        apple_x_in = 7'd9;
        apple_y_in = 6'd9;
        apple_ack  = 1'b1;
        @(posedge pclk);
        #1;
        apple_ack = 1'b0;
        checks++;
        if (apple_x !== 7'd5 || apple_y !== 6'd5) begin
            errors++;
            $display("[TB] FAIL stray_ack got (%0d,%0d) expected (5,5)", apple_x, apple_y);
        end
        do_step(1'b1, 2);
        checks++;
        if (head_x !== 7'd17 || head_y !== 6'd13) begin
            errors++;
            $display("[TB] FAIL down_not_up got (%0d,%0d) expected (17,13)", head_x, head_y);
        end
        do_step(1'b0, 0);
        checks++;
        if (head_x !== 7'd16 || head_y !== 6'd13) begin
            errors++;
            $display("[TB] FAIL move_cycle_dir got (%0d,%0d) expected (16,13)", head_x, head_y);
        end
    endtask

    task automatic test_self_collision();
        $display("[TB] test_self_collision");
        game_start(17, 12);
        do_step(1'b0, 0);
        do_ack(18, 12);
        do_step(1'b0, 0);
        do_ack(0, 0);
        checks++;
        if (snake_len !== 7'd5) begin
            errors++;
            $display("[TB] FAIL len_five got %0d expected 5", snake_len);
        end
        model_dir(1);
        do_step(1'b0, 0);
        model_dir(2);
        do_step(1'b0, 0);
        model_dir(3);
        do_step(1'b0, 0);
        checks++;
        if (game_over !== 1'b1 || head_x !== 7'd17 || head_y !== 6'd13) begin
            errors++;
            $display("[TB] FAIL self_hit got over %b head (%0d,%0d) expected 1 (17,13)",
                     game_over, head_x, head_y);
        end
    endtask

    task automatic test_reset_mid();
        $display("[TB] test_reset_mid");
        game_start(17, 12);
        do_step(1'b0, 0);
        do_ack(5, 5);
        for (int i = 0; i < FPS - 1; i++) vsync_pulse();
        vsync_in = 1'b1;
        @(posedge pclk);
        #1;
        vsync_in = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b1;
        @(posedge pclk);
        #1;
        check_reset_values("scan_reset");
        rst = 1'b0;
        @(posedge pclk);
        #1;
        checks++;
        if (apple_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req_after_init got %b expected 1", apple_req);
        end
        rst = 1'b1;
        @(posedge pclk);
        #1;
        check_reset_values("req_reset");
        rst = 1'b0;
        @(posedge pclk);
        #1;
        checks++;
        if (apple_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req_reassert got %b expected 1", apple_req);
        end
        model_init();
        do_ack(5, 5);
        do_step(1'b0, 0);
    endtask

    task automatic test_random();
        int ax, ay, k, steps;
        $display("[TB] test_random");
        for (int g = 0; g < 4; g++) begin
            game_start($urandom_range(0, GRID_W - 1), $urandom_range(0, GRID_H - 1));
            steps = 0;
            while (!m_over && steps < 30) begin
                if ($urandom_range(0, 1) == 1) model_dir($urandom_range(0, 3));
                do_step(1'($urandom_range(0, 3) == 0), $urandom_range(0, 3));
                if (!m_over) begin
                    if (apple_req === 1'b1) begin
                        if ($urandom_range(0, 1) == 1) begin
                            k  = $urandom_range(1, 2);
                            ax = qx(0) + dx_of(m_pending) * k;
                            ay = qy(0) + dy_of(m_pending) * k;
                            if (ax < 0) ax = 0;
                            if (ax > GRID_W - 1) ax = GRID_W - 1;
                            if (ay < 0) ay = 0;
                            if (ay > GRID_H - 1) ay = GRID_H - 1;
                        end else begin
                            ax = $urandom_range(0, GRID_W - 1);
                            ay = $urandom_range(0, GRID_H - 1);
                        end
                        do_ack(ax, ay);
                    end
                    check_rd($urandom_range(0, body_q.size() + 1));
                end
                steps++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_wall();
        test_grow();
        test_dir();
        test_self_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
